// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// This block shares one uart_tx serializer among NUM_REQ byte-stream
// requesters. It arbitrates round-robin at packet granularity. Once a
// requester wins, it keeps the grant from its first byte through the byte
// flagged with req_last, so packets never interleave on the serial line.
// A stall watchdog frees the grant if the owner goes quiet mid-packet.
//
// Optional feature (macro UART_ARB_HEADER_EN): after every grant, one header
// byte 8'hA0 | grant_id is sent ahead of the payload. When the macro is
// undefined, payload bytes go out unframed.
//
// Ports
//   clk, rst               single clock, synchronous active-high reset
//   req_data[8i+7:8i]      byte from requester i
//   req_valid/last/ready   per-requester handshake; last marks end of packet
//   tx_data/valid, tx_ready  one-entry output register toward uart_tx
//                          (tx_ready is high only while uart_tx is idle)
//   grant_id               current or most recent grantee
//   busy                   a packet grant is held
//   timeout                one-cycle pulse when the watchdog frees a grant

module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ*8-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       timeout
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_PKT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_id_q, grant_id_d;
   logic [GW-1:0]   last_grant_q, last_grant_d;
   logic            busy_q, busy_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;

   // Byte-lane view of the flat request data bus.
   logic [NUM_REQ-1:0][7:0] req_bytes;
   assign req_bytes = req_data;

   // Signals from the current grantee.
   logic       g_valid;
   logic       g_last;
   logic [7:0] g_data;
   assign g_valid = req_valid[grant_id_q];
   assign g_last  = req_last[grant_id_q];
   assign g_data  = req_bytes[grant_id_q];

   // The output register can take a new byte when it is empty, or when its
   // current byte is leaving on this cycle.
   logic out_free;
   assign out_free = !tx_valid_q || tx_ready;

   logic in_pkt;
   logic accept;
   logic wd_expire;
   logic hdr_load;
   assign in_pkt = (state_q == S_PKT);
   assign accept = in_pkt && g_valid && out_free;
   // If a byte is accepted on the expiry cycle, the accept wins.
   assign wd_expire = in_pkt && !accept && (wd_q == WD_LAST);

`ifdef UART_ARB_HEADER_EN
   assign hdr_load = (state_q == S_HDR) && out_free;
`else
   assign hdr_load = 1'b0;
`endif

   // Round-robin pick: take the first requesting index at or after
   // last_grant+1, wrapping modulo NUM_REQ. NUM_REQ need not be a power of
   // two, so the wrap uses an explicit modulo rather than overflow.
   logic          win_found;
   logic [GW-1:0] win_id;
   int            arb_idx;

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      arb_idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         arb_idx = (int'(last_grant_q) + k) % NUM_REQ;
         if (!win_found && req_valid[GW'(arb_idx)]) begin
            win_found = 1'b1;
            win_id    = GW'(arb_idx);
         end
      end
   end

   // Only the grantee sees ready, and only while a packet is in progress.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
      assign req_ready[i] = in_pkt && (grant_id_q == GW'(i)) && out_free;
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_id_q   <= '0;
         last_grant_q <= GW'(NUM_REQ - 1);
         busy_q       <= 1'b0;
         wd_q         <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
         wd_q         <= wd_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
`ifdef UART_ARB_HEADER_EN
               state_d = S_HDR;
`else
               state_d = S_PKT;
`endif
            end
         end
`ifdef UART_ARB_HEADER_EN
         S_HDR: begin
            if (out_free) state_d = S_PKT;
         end
`endif
         S_PKT: begin
            if ((accept && g_last) || wd_expire) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs and datapath
   // ---------------------------------------------------------------------
   always_comb begin
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      busy_d       = busy_q;
      wd_d         = '0;
      tx_data_d    = tx_data_q;

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant_id_d = win_id;
               busy_d     = 1'b1;
            end
         end
         S_PKT: begin
            if (accept) begin
               tx_data_d = g_data;
               if (g_last) begin
                  last_grant_d = grant_id_q;
                  busy_d       = 1'b0;
               end
            end else if (wd_expire) begin
               last_grant_d = grant_id_q;
               busy_d       = 1'b0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: ;
      endcase

      if (hdr_load) tx_data_d = 8'hA0 | 8'(grant_id_q);

      // The output register drains independently of the FSM state.
      if (accept || hdr_load)   tx_valid_d = 1'b1;
      else if (tx_ready)        tx_valid_d = 1'b0;
      else                      tx_valid_d = tx_valid_q;
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign grant_id = grant_id_q;
   assign busy     = busy_q;
   assign timeout  = wd_expire;

endmodule
